// File: rtl/code_decoder_pkg.sv
// Shared widths, defaults and the one-hot decode helper for the code decoder.
package code_decoder_pkg;

  localparam int CODE_W        = 3;
  localparam int ONEHOT_W      = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam int CNT_W         = 8;

  // Binary index to one-hot word; exactly one bit set for any code.
  function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
    decode = ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer with occupancy count. Push is ignored when full and pop is
// ignored when empty, so callers may drive wr_en/rd_en unconditionally.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;

  // Full/empty come from the registered level only, keeping in_ready free of
  // any path from the downstream ready.
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rptr];

  // Storage needs no reset; stale entries are never visible past level.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/code_decoder.sv
// Buffered 3-to-8 decoder: codes queue in a small FIFO, the head entry is
// presented one-hot, and consumed words are counted modulo 256.
module code_decoder
  import code_decoder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   in_code,
  output logic                in_ready,
  output logic                out_valid,
  output logic [ONEHOT_W-1:0] out_onehot,
  input  logic                out_ready,
  output logic [LW-1:0]       level,
  output logic [CNT_W-1:0]    word_cnt
);

  logic [CODE_W-1:0] head;
  logic              full, empty;

  sync_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_code),
    .rd_en   (out_ready),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_onehot = out_valid ? decode(head) : '0;

  // Count consumes only; out_ready on an empty buffer leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + 1'b1;
  end

endmodule

// File: tb/tb_code_decoder.sv
// Directed bench for code_decoder: reset, fill/drain, full and empty edges,
// streaming at constant level, counter wrap and mid-run async reset.
module tb_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_ready;
  logic [2:0] level;
  logic [7:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  code_decoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ready  (out_ready),
    .level      (level),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    in_valid = 1'b1;
    in_code  = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_head [8];
    logic [2:0] c;

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_onehot",    32'(out_onehot), 0);
    check("rst_in_ready",  32'(in_ready), 1);
    check("rst_level",     32'(level), 0);
    check("rst_word_cnt",  32'(word_cnt), 0);
    #10 rst_n = 1'b1;
    tick();

    // Single code, 1-cycle latency.
    push(3'd3);
    check("c3_valid",  32'(out_valid), 1);
    check("c3_onehot", 32'(out_onehot), 32'h08);
    check("c3_level",  32'(level), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("c3_drain_level", 32'(level), 0);
    check("c3_drain_cnt",   32'(word_cnt), 1);

    // Fill to full, then offers while full are ignored.
    push(3'd7); push(3'd0); push(3'd5); push(3'd2);
    check("full_level",    32'(level), 4);
    check("full_in_ready", 32'(in_ready), 0);
    push(3'd1);
    check("full_ignore_level", 32'(level), 4);
    check("full_head",         32'(out_onehot), 32'h80);
    // Full with a consume on the same edge: push still ignored.
    in_valid = 1'b1; in_code = 3'd1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_pop_level", 32'(level), 3);
    check("drain_01",       32'(out_onehot), 32'h01);
    tick();
    check("drain_20", 32'(out_onehot), 32'h20);
    tick();
    check("drain_04", 32'(out_onehot), 32'h04);
    tick();
    out_ready = 1'b0;
    check("drain_empty_level",  32'(level), 0);
    check("drain_empty_onehot", 32'(out_onehot), 0);
    check("drain_cnt",          32'(word_cnt), 5);

    // Streaming at level 2: heads 1,2,3,4,5,6 then leftover 7,0.
    exp_head = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    push(3'd1); push(3'd2);
    check("stream_pre_level", 32'(level), 2);
    for (int i = 0; i < 6; i++) begin
      c = 3'(3 + i);
      in_valid = 1'b1; in_code = c; out_ready = 1'b1;
      check($sformatf("stream_head%0d", i), 32'(out_onehot), 32'(exp_head[i]));
      tick();
      check($sformatf("stream_level%0d", i), 32'(level), 2);
    end
    in_valid = 1'b0;
    check("stream_tail7", 32'(out_onehot), 32'(exp_head[6]));
    tick();
    check("stream_tail0", 32'(out_onehot), 32'(exp_head[7]));
    tick();
    check("stream_cnt", 32'(word_cnt), 13);

    // Empty with out_ready high: nothing moves.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("empty_onehot%0d", i), 32'(out_onehot), 0);
      check($sformatf("empty_valid%0d", i),  32'(out_valid), 0);
      check($sformatf("empty_cnt%0d", i),    32'(word_cnt), 13);
    end
    out_ready = 1'b0;

    // Counter wrap after 257 consumes from reset.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("wrap_start_cnt", 32'(word_cnt), 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int t = 1; t <= 258; t++) begin
      in_code = 3'(t % 8);
      if (t >= 2)
        check($sformatf("wrap_head_t%0d", t), 32'(out_onehot), 32'(8'h01 << ((t - 1) % 8)));
      tick();
    end
    in_valid = 1'b0;
    check("wrap_cnt",   32'(word_cnt), 1);
    check("wrap_level", 32'(level), 1);
    check("wrap_head",  32'(out_onehot), 32'h04);
    tick();
    out_ready = 1'b0;
    check("wrap_cnt2", 32'(word_cnt), 2);

    // Asynchronous reset between edges at level 3.
    push(3'd1); push(3'd2); push(3'd3);
    check("arst_pre_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level",    32'(level), 0);
    check("arst_valid",    32'(out_valid), 0);
    check("arst_onehot",   32'(out_onehot), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_cnt",      32'(word_cnt), 0);
    #1 rst_n = 1'b1;
    push(3'd6);
    check("arst_push6",  32'(out_onehot), 32'h40);
    check("arst_level1", 32'(level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/code_decoder.md
CODE_DECODER -- requirements
Module: code_decoder

Interface
REQ-001 Parameter DEPTH, default 4, buffer entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream offers in_code this cycle.
REQ-005 in_code  input  3  binary index 0..7 to decode.
REQ-006 in_ready  output  1  block can accept a code this cycle.
REQ-007 out_valid  output  1  out_onehot holds a decoded word.
REQ-008 out_onehot  output  8  one-hot decode of the head entry: bit[in_code] set.
REQ-009 out_ready  input  1  downstream consumes the word this cycle.
REQ-010 level  output  $clog2(DEPTH)+1  number of buffered entries, 0..DEPTH.
REQ-011 word_cnt  output  8  count of words consumed; wraps 255 -> 0.

Function
REQ-012 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; the code is written at the write pointer.
REQ-013 Consume SHALL occur on an edge where out_valid=1 and out_ready=1; the read pointer advances.
REQ-014 in_ready SHALL equal (level != DEPTH), registered-state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (level != 0).
REQ-016 out_onehot SHALL be 8'h01 shifted left by the head code when out_valid=1, and 8'h00 when out_valid=0.
REQ-017 Latency SHALL be 1 cycle: a code accepted at edge N on an empty buffer is on out_onehot with out_valid=1 after edge N.
REQ-018 Codes SHALL leave in acceptance order; no drop, no duplicate.
REQ-019 Simultaneous accept and consume SHALL leave level unchanged and advance both pointers; this applies at any level from 1 to DEPTH-1.
REQ-020 When full, in_valid SHALL be ignored, even if a consume occurs on the same edge.
REQ-021 When empty, out_ready SHALL be ignored and word_cnt SHALL hold.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 word_cnt SHALL increment by 1 per consume and wrap modulo 256.
REQ-024 out_valid, out_onehot and level SHALL depend on registered state only.
REQ-025 Every out_onehot value SHALL have exactly one bit set while out_valid=1.

Reset
REQ-026 On rst_n=0, pointers, level and word_cnt SHALL go to 0 immediately, without waiting for clk.
REQ-027 During reset, out_valid=0, out_onehot=8'h00 and in_ready=1 SHALL hold.
REQ-028 Reset mid-operation SHALL discard all buffered codes; after release, the first accepted code is the next output.
REQ-029 Buffer storage contents need not be reset.

Structure
REQ-030 A shared package SHALL hold CODE_W=3, ONEHOT_W=8, default DEPTH=4 and CNT_W=8.
REQ-031 Storage and pointers SHALL be one sub-module, sync_fifo (parameter DEPTH, width CODE_W).
REQ-032 The decode and word_cnt logic SHALL reside in code_decoder.

Verification
REQ-033 Reset, then push code 3 with out_ready=0 -> after next edge out_valid=1, out_onehot=8'h08, level=1.
REQ-034 Push codes 7,0,5,2 with out_ready=0 -> level=4, in_ready=0; a 5th in_valid is ignored; draining gives 8'h80, 8'h01, 8'h20, 8'h04.
REQ-035 At level=2, hold in_valid=1 and out_ready=1 for 6 cycles -> level stays 2 and outputs match input order.
REQ-036 Empty buffer, out_ready=1 for 3 cycles -> out_onehot=8'h00 and word_cnt unchanged.
REQ-037 Consume 257 words -> word_cnt=1.
REQ-038 Assert rst_n=0 between edges at level=3 -> level=0, out_valid=0 at once; after release, push 6 -> 8'h40.
